// File: rtl/conv2d_edge_mul_arb_pkg.sv
// Shared widths, constants and types for the conv2d edge multiplier arbiter.
// The optional grant statistics are enabled with CONV2D_EDGE_MUL_ARB_STATS_EN.
package conv2d_edge_mul_arb_pkg;

    localparam int DEF_A_W = 8;
    localparam int DEF_B_W = 10;
    localparam int DEF_P_W = 18;
    localparam int MAX_REQ = 8;
    localparam int STAT_W  = 16;

    // Tag width for n requesters; a single requester still gets one bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } res_state_e;

endpackage

// File: rtl/conv2d_edge_rr_arbiter.sv
// Combinational rotating-priority arbiter: grants the first request found
// searching upward from ptr_i, wrapping modulo N.
module conv2d_edge_rr_arbiter
    import conv2d_edge_mul_arb_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = clog2_min1(N)
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] ptr_i,
    input  logic           en_i,
    output logic [N-1:0]   gnt_o,
    output logic [IDW-1:0] idx_o,
    output logic           vld_o
);

    always_comb begin
        int j;
        j     = 0;
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr_i) + k;
            if (j >= N) j = j - N;
            if (en_i && !vld_o && req_i[j]) begin
                vld_o    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/conv2d_edge_mul_arbiter.sv
// One unsigned multiplier shared round-robin between NUM_REQ requesters, with a
// registered, tagged valid/ready result. Define CONV2D_EDGE_MUL_ARB_STATS_EN for grant counters.
module conv2d_edge_mul_arbiter
    import conv2d_edge_mul_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int A_W     = DEF_A_W,
    parameter int B_W     = DEF_B_W,
    parameter int P_W     = DEF_P_W,
    parameter int ID_W    = clog2_min1(NUM_REQ)
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*A_W-1:0] req_a,
    input  logic [NUM_REQ*B_W-1:0] req_b,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [P_W-1:0]         res_data,
    output logic [ID_W-1:0]        res_id
`ifdef CONV2D_EDGE_MUL_ARB_STATS_EN
    ,
    input  logic                   stat_clr,
    input  logic [ID_W-1:0]        stat_sel,
    output logic [STAT_W-1:0]      stat_cnt
`endif
);

    res_state_e                  state_q, state_d;
    logic [ID_W-1:0]             rr_ptr_q, rr_ptr_d;
    logic [P_W-1:0]              res_data_q, res_data_d;
    logic [ID_W-1:0]             res_id_q, res_id_d;
    logic [NUM_REQ-1:0]          gnt;
    logic [ID_W-1:0]             gnt_idx;
    logic                        gnt_vld;
    logic                        can_accept;
    logic                        accept;
    logic [NUM_REQ-1:0][A_W-1:0] a_arr;
    logic [NUM_REQ-1:0][B_W-1:0] b_arr;
    logic [A_W-1:0]              op_a;
    logic [B_W-1:0]              op_b;
    logic [A_W+B_W-1:0]          prod;

    assign a_arr = req_a;
    assign b_arr = req_b;

    // Reset gates the enable so no grant is visible while ap_rst_n is low.
    assign can_accept = (state_q == EMPTY) || res_ready;

    conv2d_edge_rr_arbiter #(
        .N   (NUM_REQ),
        .IDW (ID_W)
    ) u_arb (
        .req_i (req_valid),
        .ptr_i (rr_ptr_q),
        .en_i  (can_accept && ap_rst_n),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .vld_o (gnt_vld)
    );

    assign req_ready = gnt;
    assign accept    = gnt_vld;

    assign op_a = a_arr[gnt_idx];
    assign op_b = b_arr[gnt_idx];
    assign prod = {{B_W{1'b0}}, op_a} * {{A_W{1'b0}}, op_b};

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        res_data_d = res_data_q;
        res_id_d   = res_id_q;
        if (accept) begin
            state_d    = FULL;
            res_data_d = P_W'(prod);
            res_id_d   = gnt_idx;
            rr_ptr_d   = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end else if (state_q == FULL && res_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q    <= EMPTY;
            rr_ptr_q   <= '0;
            res_data_q <= '0;
            res_id_q   <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            res_data_q <= res_data_d;
            res_id_q   <= res_id_d;
        end
    end

    assign res_valid = (state_q == FULL);
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;

`ifdef CONV2D_EDGE_MUL_ARB_STATS_EN
    logic [STAT_W-1:0] cnt_q [NUM_REQ];
    logic [STAT_W-1:0] stat_cnt_q;

    // Clear wins over a same-cycle increment; counters saturate at all-ones.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
            stat_cnt_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (stat_clr)
                    cnt_q[i] <= '0;
                else if (gnt[i] && cnt_q[i] != '1)
                    cnt_q[i] <= cnt_q[i] + 1'b1;
            end
            stat_cnt_q <= cnt_q[stat_sel];
        end
    end

    assign stat_cnt = stat_cnt_q;
`endif

endmodule

// File: tb/tb_conv2d_edge_mul_arbiter.sv
// Directed table-driven bench for conv2d_edge_mul_arbiter (default parameters).
module tb_conv2d_edge_mul_arbiter;

    logic        ap_clk;
    logic        ap_rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [39:0] req_b;
    logic        res_valid;
    logic        res_ready;
    logic [17:0] res_data;
    logic [1:0]  res_id;
`ifdef CONV2D_EDGE_MUL_ARB_STATS_EN
    logic        stat_clr;
    logic [1:0]  stat_sel;
    logic [15:0] stat_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    conv2d_edge_mul_arbiter dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id)
`ifdef CONV2D_EDGE_MUL_ARB_STATS_EN
        ,
        .stat_clr  (stat_clr),
        .stat_sel  (stat_sel),
        .stat_cnt  (stat_cnt)
`endif
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    typedef struct {
        logic [3:0]  v;
        logic [31:0] a;
        logic [39:0] b;
        logic        rdy;
        logic [3:0]  e_rr;
        logic        e_v;
        logic [17:0] e_d;
        logic [1:0]  e_id;
    } vec_t;

    function automatic logic [31:0] pa(input int a0, input int a1, input int a2, input int a3);
        return {8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    endfunction

    function automatic logic [39:0] pb(input int b0, input int b1, input int b2, input int b3);
        return {10'(b3), 10'(b2), 10'(b1), 10'(b0)};
    endfunction

    function automatic vec_t mk(input logic [3:0] v, input logic [31:0] a, input logic [39:0] b,
                                input logic rdy, input logic [3:0] e_rr, input logic e_v,
                                input int e_d, input int e_id);
        vec_t t;
        t.v = v; t.a = a; t.b = b; t.rdy = rdy;
        t.e_rr = e_rr; t.e_v = e_v; t.e_d = 18'(e_d); t.e_id = 2'(e_id);
        return t;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Entered just after a rising edge; leaves just after the next one.
    task automatic apply(input vec_t t, input string tag);
        req_valid = t.v;
        req_a     = t.a;
        req_b     = t.b;
        res_ready = t.rdy;
        #1;
        chk({tag, " req_ready"}, 64'(req_ready), 64'(t.e_rr));
        @(posedge ap_clk);
        #1;
        chk({tag, " res_valid"}, 64'(res_valid), 64'(t.e_v));
        chk({tag, " res_data"}, 64'(res_data), 64'(t.e_d));
        chk({tag, " res_id"}, 64'(res_id), 64'(t.e_id));
    endtask

    initial begin
        vec_t tbl[$];
        logic [31:0] a4;
        logic [39:0] b4;

        a4 = pa(1, 2, 3, 4);
        b4 = pb(10, 20, 30, 40);
        // All requesters valid: strict 0,1,2,3,0 rotation, no bubbles
        tbl.push_back(mk(4'b1111, a4, b4, 1'b1, 4'b0001, 1'b1, 10, 0));
        tbl.push_back(mk(4'b1111, a4, b4, 1'b1, 4'b0010, 1'b1, 40, 1));
        tbl.push_back(mk(4'b1111, a4, b4, 1'b1, 4'b0100, 1'b1, 90, 2));
        tbl.push_back(mk(4'b1111, a4, b4, 1'b1, 4'b1000, 1'b1, 160, 3));
        tbl.push_back(mk(4'b1111, a4, b4, 1'b1, 4'b0001, 1'b1, 10, 0));
        tbl.push_back(mk(4'b0000, a4, b4, 1'b1, 4'b0000, 1'b0, 10, 0));
        // Single requester at full-scale operands, then drain
        tbl.push_back(mk(4'b0010, pa(0, 255, 0, 0), pb(0, 1023, 0, 0), 1'b1, 4'b0010, 1'b1, 260865, 1));
        tbl.push_back(mk(4'b0000, pa(0, 255, 0, 0), pb(0, 1023, 0, 0), 1'b1, 4'b0000, 1'b0, 260865, 1));
        // Park pointer at 3, then wrap to req0 and skip to req2
        tbl.push_back(mk(4'b0100, pa(0, 0, 5, 0), pb(0, 0, 6, 0), 1'b1, 4'b0100, 1'b1, 30, 2));
        tbl.push_back(mk(4'b0101, pa(7, 0, 9, 0), pb(8, 0, 11, 0), 1'b1, 4'b0001, 1'b1, 56, 0));
        tbl.push_back(mk(4'b0101, pa(7, 0, 9, 0), pb(8, 0, 11, 0), 1'b1, 4'b0100, 1'b1, 99, 2));
        tbl.push_back(mk(4'b0000, pa(7, 0, 9, 0), pb(8, 0, 11, 0), 1'b1, 4'b0000, 1'b0, 99, 2));
        // Backpressure: 21 held for 5 cycles with new requests pending
        tbl.push_back(mk(4'b0001, pa(3, 0, 0, 0), pb(7, 0, 0, 0), 1'b0, 4'b0001, 1'b1, 21, 0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(4'b0011, pa(4, 6, 0, 0), pb(5, 6, 0, 0), 1'b0, 4'b0000, 1'b1, 21, 0));
        tbl.push_back(mk(4'b0011, pa(4, 6, 0, 0), pb(5, 6, 0, 0), 1'b1, 4'b0010, 1'b1, 36, 1));
        tbl.push_back(mk(4'b0001, pa(4, 0, 0, 0), pb(5, 0, 0, 0), 1'b1, 4'b0001, 1'b1, 20, 0));
        tbl.push_back(mk(4'b0000, pa(4, 0, 0, 0), pb(5, 0, 0, 0), 1'b1, 4'b0000, 1'b0, 20, 0));

        ap_rst_n  = 1'b0;
        req_valid = 4'b1111;
        req_a     = a4;
        req_b     = b4;
        res_ready = 1'b1;
`ifdef CONV2D_EDGE_MUL_ARB_STATS_EN
        stat_clr  = 1'b0;
        stat_sel  = 2'd0;
`endif
        #3;
        chk("reset req_ready", 64'(req_ready), 64'h0);
        chk("reset res_valid", 64'(res_valid), 64'h0);
        chk("reset res_data", 64'(res_data), 64'h0);
        chk("reset res_id", 64'(res_id), 64'h0);
        req_valid = 4'b0000;
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // Reset while a result is pending under backpressure (pointer at 2)
        apply(mk(4'b0010, pa(0, 2, 0, 0), pb(0, 3, 0, 0), 1'b0, 4'b0010, 1'b1, 6, 1), "pre_rst");
        #2;
        res_ready = 1'b1;
        ap_rst_n  = 1'b0;
        #1;
        chk("midrst res_valid", 64'(res_valid), 64'h0);
        chk("midrst res_data", 64'(res_data), 64'h0);
        chk("midrst res_id", 64'(res_id), 64'h0);
        chk("midrst req_ready", 64'(req_ready), 64'h0);
        req_valid = 4'b0000;
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
        // Pointer back at 0: req0 beats req2
        apply(mk(4'b0101, pa(1, 0, 2, 0), pb(1, 0, 2, 0), 1'b1, 4'b0001, 1'b1, 1, 0), "post_rst0");
        apply(mk(4'b1000, pa(0, 0, 0, 12), pb(0, 0, 0, 13), 1'b1, 4'b1000, 1'b1, 156, 3), "post_rst3");
        apply(mk(4'b0000, pa(0, 0, 0, 12), pb(0, 0, 0, 13), 1'b1, 4'b0000, 1'b0, 156, 3), "post_rst_drain");

`ifdef CONV2D_EDGE_MUL_ARB_STATS_EN
        req_valid = 4'b0001;
        req_a     = pa(3, 0, 0, 0);
        req_b     = pb(7, 0, 0, 0);
        res_ready = 1'b1;
        stat_sel  = 2'd0;
        repeat (70000) @(posedge ap_clk);
        #1;
        req_valid = 4'b0000;
        @(posedge ap_clk);
        #1;
        chk("stat sat0", 64'(stat_cnt), 64'hFFFF);
        stat_sel = 2'd3;
        @(posedge ap_clk);
        #1;
        chk("stat cnt3", 64'(stat_cnt), 64'h1);
        req_valid = 4'b0001;
        stat_clr  = 1'b1;
        stat_sel  = 2'd0;
        @(posedge ap_clk);
        #1;
        stat_clr  = 1'b0;
        req_valid = 4'b0000;
        @(posedge ap_clk);
        #1;
        chk("stat clr0", 64'(stat_cnt), 64'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
